// File: rtl/switch_debouncer_pkg.sv
// Shared switch-bank types and constants used by the debouncer and by the
// board-level code that instantiates it.
package switch_debouncer_pkg;

   // Switch bank as seen by the chipset.
   typedef logic [15:0] switch_t;

   // Stable-cycle count used by the board when instantiating the debouncer.
   localparam int unsigned SWITCH_DEBOUNCE_CYCLES = 250_000;

   // Counter width for a given stable-cycle count (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One debounced switch bit. The debounced value follows the synchronised
// input only after the input has disagreed with it for STABLE_CYCLES
// consecutive edges; any return to the old value restarts the count.
// rise_o pulses for one cycle in the cycle the debounced value changes.
module switch_debouncer_debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = SWITCH_DEBOUNCE_CYCLES,
   parameter logic        RESET_VALUE   = 1'b0
) (
   input  logic clk_cpu_i,
   input  logic reset_async_ni,
   input  logic sync_i,
   output logic switch_o,
   output logic rise_o
);

   localparam int unsigned   CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          switch_q;
   logic          switch_d;
   logic          rise;

   // Count consecutive disagreeing edges; commit the new value on the last one.
   always_comb begin
      cnt_d    = cnt_q;
      switch_d = switch_q;
      rise     = 1'b0;
      if (sync_i == switch_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         switch_d = sync_i;
         cnt_d    = '0;
         rise     = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter and debounced value; reset discards any partial count.
   always_ff @(posedge clk_cpu_i or negedge reset_async_ni) begin
      if (!reset_async_ni) begin
         cnt_q    <= '0;
         switch_q <= RESET_VALUE;
      end else begin
         cnt_q    <= cnt_d;
         switch_q <= switch_d;
      end
   end

   assign switch_o = switch_q;
   assign rise_o   = rise;

endmodule

// File: rtl/switch_debouncer.sv
// Switch-bank debouncer: two-flop synchroniser per bit, independent per-bit
// debounce, and a sticky change mask offered to the CPU side as a
// valid/ready event. event_data_o is the live debounced value.
// Build option: SWITCH_DEBOUNCE_BYPASS_EN removes the debounce counters and
// lets the synchronised value straight through (simulation / bring-up).
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned       WIDTH         = 16,
   parameter int unsigned       STABLE_CYCLES = SWITCH_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
   input  logic             clk_cpu_i,
   input  logic             reset_async_ni,
   input  logic [WIDTH-1:0] switch_async_i,
   output logic [WIDTH-1:0] switch_o,
   output logic             event_valid_o,
   input  logic             event_ready_i,
   output logic [WIDTH-1:0] event_mask_o,
   output logic [WIDTH-1:0] event_data_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_d;
   logic [WIDTH-1:0] switch_w;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] mask_d;
   logic             valid_q;
   logic             valid_d;
   logic             handshake;

   // Synchroniser chain next-state.
   always_comb begin
      meta_d = switch_async_i;
      sync_d = meta_q;
   end

   // Synchroniser flops; reset loads the debounced reset value so no change is seen.
   always_ff @(posedge clk_cpu_i or negedge reset_async_ni) begin
      if (!reset_async_ni) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

`ifdef SWITCH_DEBOUNCE_BYPASS_EN
   logic [WIDTH-1:0] switch_q;
   logic [WIDTH-1:0] switch_d;

   // Bypass: debounced value simply follows the synchronised input.
   always_comb begin
      switch_d = sync_q;
      rise     = switch_d ^ switch_q;
   end

   // Bypass debounced-value register.
   always_ff @(posedge clk_cpu_i or negedge reset_async_ni) begin
      if (!reset_async_ni) begin
         switch_q <= RESET_VALUE;
      end else begin
         switch_q <= switch_d;
      end
   end

   assign switch_w = switch_q;
`else
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         switch_debouncer_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE[gi])
         ) u_debounce_bit (
            .clk_cpu_i      (clk_cpu_i),
            .reset_async_ni (reset_async_ni),
            .sync_i         (sync_q[gi]),
            .switch_o       (switch_w[gi]),
            .rise_o         (rise[gi])
         );
      end
   endgenerate
`endif

   // Sticky change mask: cleared by an accepted event, but a change landing
   // in the accept cycle is kept. Valid is registered from the next mask so
   // it tracks the mask exactly with no path from ready.
   always_comb begin
      handshake = valid_q & event_ready_i;
      mask_d    = (handshake ? '0 : mask_q) | rise;
      valid_d   = |mask_d;
   end

   // Event mask and valid registers.
   always_ff @(posedge clk_cpu_i or negedge reset_async_ni) begin
      if (!reset_async_ni) begin
         mask_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         valid_q <= valid_d;
      end
   end

   assign switch_o      = switch_w;
   assign event_data_o  = switch_w;
   assign event_mask_o  = mask_q;
   assign event_valid_o = valid_q;

endmodule
